lcd_status_reader: RTL

//  Read side of the HD44780 character-LCD bus: runs instruction-register read cycles (RS=0, RW=1)
//  and returns the busy flag (DB7) and the 7-bit address counter (DB6:0).

---
 rtl/lcd_status_reader_pkg.sv | 38 +++
 rtl/lcd_status_reader_phase_timer.sv | 39 +++
 rtl/lcd_status_reader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_status_reader_pkg.sv
// Shared HD44780 bus definitions: default timing, bus constants and read FSM states.
// Used by both the status reader and the LCD write driver.
package lcd_defs;

  localparam int SETUP_CYCLES_DEF   = 4;
  localparam int EN_HIGH_CYCLES_DEF = 16;
  localparam int HOLD_CYCLES_DEF    = 4;
  localparam int EN_LOW_CYCLES_DEF  = 12;
  localparam int POLL_LIMIT_DEF     = 50000;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_GNT = 3'd1,
    ST_SETUP    = 3'd2,
    ST_EN_HIGH  = 3'd3,
    ST_HOLD     = 3'd4,
    ST_EN_LOW   = 3'd5,
    ST_DONE     = 3'd6
  } lcd_state_e;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Width that holds 0..n-1, never below one bit.
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_status_reader_phase_timer.sv
// Down-counting phase timer: load N-1, count to zero, expired flags the phase's last clock.
// Reusable by the LCD write driver for its own bus phases.
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload wins, otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 instruction-register reader: arbitrates for the LCD pins, runs RS=0/RW=1 read
// cycles and returns BF/AC, optionally re-reading until the controller reports not-busy.
module lcd_status_reader
  import lcd_defs::*;
#(
  parameter int SETUP_CYCLES   = SETUP_CYCLES_DEF,
  parameter int EN_HIGH_CYCLES = EN_HIGH_CYCLES_DEF,
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int EN_LOW_CYCLES  = EN_LOW_CYCLES_DEF,
  parameter int POLL_LIMIT     = POLL_LIMIT_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       poll,
  output logic       bus_req,
  input  logic       bus_gnt,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_read,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       busy,
  output logic       done,
  output logic       bf,
  output logic [6:0] ac,
  output logic       timeout
);

  localparam int PW  = ctr_width(max_of4(SETUP_CYCLES, EN_HIGH_CYCLES, HOLD_CYCLES, EN_LOW_CYCLES));
  localparam int RCW = ctr_width(POLL_LIMIT + 1);
  localparam logic [RCW-1:0] READS_MAX = RCW'(POLL_LIMIT);

  lcd_state_e     state_q, state_d;
  logic           poll_q, poll_d;
  logic [RCW-1:0] reads_q, reads_d;
  logic           bf_q, bf_d;
  logic [6:0]     ac_q, ac_d;
  logic           timeout_q, timeout_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           bus_req_q, bus_req_d;
  logic           lcd_read_q, lcd_read_d;
  logic           lcd_rw_q, lcd_rw_d;
  logic           lcd_en_q, lcd_en_d;
  logic           pins_d;
  logic           tmr_load;
  logic [PW-1:0]  tmr_val;
  logic           tmr_expired;

  lcd_phase_timer #(.W(PW)) u_phase_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Next state, capture of BF/AC and poll bookkeeping; outputs decoded from the next state
  // so every pin comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    poll_d    = poll_q;
    reads_d   = reads_q;
    bf_d      = bf_q;
    ac_d      = ac_q;
    timeout_d = timeout_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          poll_d    = poll;
          timeout_d = 1'b0;
          reads_d   = '0;
          state_d   = ST_WAIT_GNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_GNT: begin
        if (bus_gnt) begin
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = PW'(SETUP_CYCLES - 1);
        end else begin
          state_d = ST_WAIT_GNT;
        end
      end
      ST_SETUP: begin
        if (tmr_expired) begin
          state_d  = ST_EN_HIGH;
          tmr_load = 1'b1;
          tmr_val  = PW'(EN_HIGH_CYCLES - 1);
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_EN_HIGH: begin
        if (tmr_expired) begin
          bf_d     = lcd_data_in[7];
          ac_d     = lcd_data_in[6:0];
          reads_d  = (reads_q == READS_MAX) ? reads_q : reads_q + RCW'(1);
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = PW'(HOLD_CYCLES - 1);
        end else begin
          state_d = ST_EN_HIGH;
        end
      end
      ST_HOLD: begin
        if (tmr_expired) begin
          state_d  = ST_EN_LOW;
          tmr_load = 1'b1;
          tmr_val  = PW'(EN_LOW_CYCLES - 1);
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_EN_LOW: begin
        if (!tmr_expired) begin
          state_d = ST_EN_LOW;
        end else if (!poll_q || !bf_q) begin
          state_d = ST_DONE;
        end else if (reads_q < READS_MAX) begin
          // Still busy: go straight back to SETUP, the pins stay ours.
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = PW'(SETUP_CYCLES - 1);
        end else begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pins_d     = (state_d == ST_SETUP) || (state_d == ST_EN_HIGH) ||
                 (state_d == ST_HOLD)  || (state_d == ST_EN_LOW);
    busy_d     = pins_d || (state_d == ST_WAIT_GNT);
    bus_req_d  = busy_d;
    lcd_read_d = pins_d;
    lcd_rw_d   = pins_d ? RW_READ : ~RW_READ;
    lcd_en_d   = (state_d == ST_EN_HIGH);
    done_d     = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      poll_q     <= 1'b0;
      reads_q    <= '0;
      bf_q       <= 1'b0;
      ac_q       <= 7'h00;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      lcd_read_q <= 1'b0;
      lcd_rw_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_q     <= poll_d;
      reads_q    <= reads_d;
      bf_q       <= bf_d;
      ac_q       <= ac_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      bus_req_q  <= bus_req_d;
      lcd_read_q <= lcd_read_d;
      lcd_rw_q   <= lcd_rw_d;
      lcd_en_q   <= lcd_en_d;
    end
  end

  assign bus_req  = bus_req_q;
  assign lcd_read = lcd_read_q;
  assign lcd_rs   = RS_INSTR;
  assign lcd_rw   = lcd_rw_q;
  assign lcd_en   = lcd_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign bf       = bf_q;
  assign ac       = ac_q;
  assign timeout  = timeout_q;

endmodule
